pwm_multi: RTL and testbench
============================

# pwm_multi

Multi-channel, parametrised PWM generator sharing one time base across channels. Successor to the single-channel 4-bit PWM. Adds:
- a configurable period and prescaler;
- edge- or center-aligned mode;
- shadow-buffered duty registers that update glitch-free at period boundaries;
- a period-start strobe.

Sits between the ALU/register interface and the motor/LED pins.

## Interface
- WIDTH, 4: counter, period and duty width
- CHANNELS, 4: number of PWM outputs
- PRESC_W, 8: prescaler width
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- en  in  1  run enable
- center  in  1  mode request: 0 = edge-aligned, 1 = center-aligned
- prescale  in  PRESC_W  one tick every prescale+1 clk cycles
- period  in  WIDTH  counter top value
- duty_in  in  WIDTH  duty value to write
- duty_we  in  CHANNELS  per-channel write strobe; may be multi-hot; writes duty_in into each selected shadow
- pwm  out  CHANNELS  PWM outputs, registered
- cycle_start  out  1  one-clk pulse at each period start

## Operation
- **Prescaler:** psc counts 0..prescale. tick=1 when psc==prescale; psc returns to 0 on that cycle. prescale=0 gives tick every clk.
- **Edge mode:** on tick, cnt goes 0,1,…,period_act, then 0. Period = period_act+1 ticks.
- **Center mode:** cnt counts up 0..period_act, then down to 0.
  - dir flips to down at period_act and to up at 0.
  - Period = 2·period_act ticks.
- **period_act=0:** cnt stays 0 in either mode; every tick is a boundary.
- **Boundary:** the tick on which cnt becomes 0. Transitions are period_act→0 (edge) or 1→0 with dir=down (center). On a boundary:
  - duty_act[i] ← shadow[i]
  - period_act ← period
  - mode_act ← center
  - dir ← up
  - cycle_start=1 on the next cycle
- **Shadow writes:** shadow[i] ← duty_in for each set duty_we bit, on any cycle.
  - Write coinciding with a boundary: the new value goes straight to duty_act (write-through).
  - The current period never changes mid-cycle.
- **Compare:** pwm[i] ← en & (cnt < duty_act[i]), unsigned compare.
  - duty 0 → output always low.
  - duty > period_act (edge mode) → output always high.
- **en=0:**
  - psc, cnt = 0; dir = up; pwm = 0; cycle_start = 0.
  - Active registers load from shadow/period/center every cycle.
  - Shadow writes are still accepted.
- **en 0→1:** first cycle is a period start at cnt=0 with the latest values; cycle_start pulses on it.
- **Arithmetic:** all counters wrap-free by construction (compare-and-reset, never overflow). Counter width is WIDTH. Compares are unsigned.

## Timing
- **Reset values:** psc, cnt, shadow, duty_act, period_act = 0; mode_act = edge; dir = up; pwm = 0; cycle_start = 0.
- **Reset mid-operation:** all state, including shadows, is cleared next cycle.
- **Output latency:** pwm lags the cnt value it reflects by 1 clk. cycle_start is aligned with the first pwm cycle of the new period.
- **Write latency:** a duty write at cycle t affects pwm no earlier than 1 clk after the next boundary after t.
- **Parameter changes:** period, prescale and center changes never produce runt pulses.
  - period and center are sampled at boundaries only.
  - prescale is used live; a change is only guaranteed clean if applied with en=0.

## Structure
- Package pwm_pkg:
  - typedef pwm_mode_e {PWM_EDGE, PWM_CENTER}
  - default WIDTH/CHANNELS/PRESC_W localparams
  - direction typedef
- Sub-module pwm_prescaler (clk, rst, en, prescale → tick) isolates the clock divider.
- Per-channel shadow/active/compare logic is a generate loop inside pwm_multi. No separate module.

## Test plan
1. **Edge basic.** prescale=0, period=15, duty ch0=4, en=1 → pwm[0] high 4 of every 16 clk; cycle_start every 16 clk.
2. **Shadow update.** Write duty 10 to ch0 at cnt=5 → remainder of current period keeps 4-high; next period is 10-high. Write on a boundary cycle → that period is already 10.
3. **Extremes.** duty 0 → constant 0. period=14, duty=15 → constant 1. duty=period=7 → 7 high of 8. duty_we=4'b1111 loads all channels identically.
4. **Prescaler.** prescale=2, period=3, duty=2 → 6 clk high, 6 clk low, cycle_start every 12 clk.
5. **Center mode.** period=4, duty=2 → cnt sequence 0,1,2,3,4,3,2,1 repeating; pwm high 3 of 8 ticks; cycle_start every 8 ticks. Mode switch requested mid-period takes effect only at the boundary.
6. **Disable/reset mid-period.**
   - en→0 at cnt=9 → pwm=0 next clk; en→1 restarts at cnt=0 with a cycle_start pulse.
   - rst mid-period → all outputs 0, shadows 0.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and default sizing for the multi-channel PWM generator.
package pwm_pkg;

    localparam int PWM_WIDTH_DEF    = 4;
    localparam int PWM_CHANNELS_DEF = 4;
    localparam int PWM_PRESC_W_DEF  = 8;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    // Unsigned compare that decides one channel's level for a given count.
    function automatic logic pwm_level(input logic run, input int unsigned cnt,
                                       input int unsigned duty);
        return run && (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: one tick every prescale+1 clk cycles while enabled.
module pwm_prescaler
    import pwm_pkg::*;
#(
    parameter int PRESC_W = PWM_PRESC_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [PRESC_W-1:0] prescale,
    output logic               tick
);

    logic [PRESC_W-1:0] psc;

    // Compare with >= so a live decrease of prescale cannot strand psc above it.
    assign tick = en && (psc >= prescale);

    // Divider counter, held at zero while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc <= {PRESC_W{1'b0}};
        end else if (!en || tick) begin
            psc <= {PRESC_W{1'b0}};
        end else begin
            psc <= psc + {{(PRESC_W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shared time base, edge/center modes and shadowed duty registers
// that only take effect at period boundaries.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH    = PWM_WIDTH_DEF,
    parameter int CHANNELS = PWM_CHANNELS_DEF,
    parameter int PRESC_W  = PWM_PRESC_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                center,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [WIDTH-1:0]    period,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic [CHANNELS-1:0] duty_we,
    output logic [CHANNELS-1:0] pwm,
    output logic                cycle_start
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

    logic                           tick;
    logic [WIDTH-1:0]               cnt;
    logic [WIDTH-1:0]               cnt_next;
    logic [WIDTH-1:0]               period_act;
    pwm_mode_e                      mode_act;
    pwm_dir_e                       dir;
    pwm_dir_e                       dir_next;
    logic                           boundary;
    logic                           load_act;
    logic                           at_start;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow;
    logic [CHANNELS-1:0][WIDTH-1:0] shadow_nxt;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act;
    logic [CHANNELS-1:0][WIDTH-1:0] duty_act_nxt;
    logic [CHANNELS-1:0]            pwm_nxt;

    pwm_prescaler #(
        .PRESC_W (PRESC_W)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prescale (prescale),
        .tick     (tick)
    );

    // Next count/direction for the active mode; cnt never exceeds period_act.
    always_comb begin
        cnt_next = cnt;
        dir_next = dir;
        if (mode_act == PWM_EDGE) begin
            dir_next = DIR_UP;
            if (cnt >= period_act) begin
                cnt_next = CNT_ZERO;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end else begin
            if (dir == DIR_UP && cnt < period_act) begin
                cnt_next = cnt + CNT_ONE;
                dir_next = DIR_UP;
            end else begin
                // Turning point or descending slope; zero stays at zero.
                cnt_next = (cnt == CNT_ZERO) ? CNT_ZERO : cnt - CNT_ONE;
                dir_next = DIR_DOWN;
            end
        end
    end

    assign boundary = tick && (cnt_next == CNT_ZERO);
    assign load_act = !en || boundary;

    // Per-channel shadow, write-through into the active duty, and compare.
    for (genvar i = 0; i < CHANNELS; i++) begin : gen_ch
        assign shadow_nxt[i]   = duty_we[i] ? duty_in : shadow[i];
        assign duty_act_nxt[i] = load_act ? shadow_nxt[i] : duty_act[i];
        assign pwm_nxt[i]      = pwm_level(en, int'(cnt), int'(duty_act[i]));
    end

    // Shared time base and period-level active configuration.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt         <= CNT_ZERO;
            dir         <= DIR_UP;
            period_act  <= CNT_ZERO;
            mode_act    <= PWM_EDGE;
            at_start    <= 1'b1;
            cycle_start <= 1'b0;
        end else if (!en) begin
            cnt         <= CNT_ZERO;
            dir         <= DIR_UP;
            period_act  <= period;
            mode_act    <= pwm_mode_e'(center);
            at_start    <= 1'b1;
            cycle_start <= 1'b0;
        end else begin
            // at_start marks cnt==0 of a new period; the strobe follows with pwm.
            cycle_start <= at_start;
            at_start    <= boundary;
            if (tick) begin
                cnt <= cnt_next;
                dir <= boundary ? DIR_UP : dir_next;
            end else begin
                cnt <= cnt;
                dir <= dir;
            end
            if (boundary) begin
                period_act <= period;
                mode_act   <= pwm_mode_e'(center);
            end else begin
                period_act <= period_act;
                mode_act   <= mode_act;
            end
        end
    end

    // Duty storage and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow   <= '0;
            duty_act <= '0;
            pwm      <= {CHANNELS{1'b0}};
        end else begin
            shadow   <= shadow_nxt;
            duty_act <= duty_act_nxt;
            pwm      <= pwm_nxt;
        end
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Randomized self-checking bench for pwm_multi against a position-within-period model.
module tb_pwm_multi;

    localparam int WIDTH    = 4;
    localparam int CHANNELS = 4;
    localparam int PRESC_W  = 8;

    logic                clk = 1'b0;
    logic                rst;
    logic                en;
    logic                center;
    logic [PRESC_W-1:0]  prescale;
    logic [WIDTH-1:0]    period;
    logic [WIDTH-1:0]    duty_in;
    logic [CHANNELS-1:0] duty_we;
    logic [CHANNELS-1:0] pwm;
    logic                cycle_start;

    int checks = 0;
    int errors = 0;

    // Reference model: position inside the current period rather than a counter.
    int  m_psc;
    int  m_pos;
    int  m_p;
    bit  m_center;
    bit  m_first;
    int  m_sh  [CHANNELS];
    int  m_act [CHANNELS];
    logic [CHANNELS-1:0] exp_pwm;
    logic                exp_cs;

    pwm_multi #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .PRESC_W  (PRESC_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .center      (center),
        .prescale    (prescale),
        .period      (period),
        .duty_in     (duty_in),
        .duty_we     (duty_we),
        .pwm         (pwm),
        .cycle_start (cycle_start)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int len_of(input int p, input bit c);
        if (p == 0) return 1;
        return c ? 2 * p : p + 1;
    endfunction

    function automatic int cnt_of(input int pos, input int p, input bit c);
        if (!c) return pos;
        return (pos <= p) ? pos : 2 * p - pos;
    endfunction

    task automatic model_reset();
        m_psc    = 0;
        m_pos    = 0;
        m_p      = 0;
        m_center = 1'b0;
        m_first  = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            m_sh[i]  = 0;
            m_act[i] = 0;
        end
        exp_pwm = '0;
        exp_cs  = 1'b0;
    endtask

    task automatic model_step();
        int nsh [CHANNELS];
        int c;
        bit tick;
        if (rst) begin
            model_reset();
            return;
        end
        c = cnt_of(m_pos, m_p, m_center);
        for (int i = 0; i < CHANNELS; i++) begin
            exp_pwm[i] = en && (c < m_act[i]);
            nsh[i]     = duty_we[i] ? int'(duty_in) : m_sh[i];
        end
        exp_cs = en && m_first;
        if (!en) begin
            m_psc    = 0;
            m_pos    = 0;
            m_p      = int'(period);
            m_center = center;
            m_act    = nsh;
            m_first  = 1'b1;
        end else begin
            tick    = (m_psc >= int'(prescale));
            m_first = 1'b0;
            if (tick) begin
                m_psc = 0;
                if (m_pos + 1 >= len_of(m_p, m_center)) begin
                    m_pos    = 0;
                    m_p      = int'(period);
                    m_center = center;
                    m_act    = nsh;
                    m_first  = 1'b1;
                end else begin
                    m_pos++;
                end
            end else begin
                m_psc++;
            end
        end
        m_sh = nsh;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_eq("pwm", 32'(pwm), 32'(exp_pwm));
        check_eq("cycle_start", 32'(cycle_start), 32'(exp_cs));
    endtask

    function automatic logic [WIDTH-1:0] rand_duty();
        int r;
        r = int'($urandom_range(0, 9));
        if (r == 0) return WIDTH'(0);
        if (r == 1) return WIDTH'((1 << WIDTH) - 1);
        return WIDTH'($urandom_range(0, (1 << WIDTH) - 1));
    endfunction

    initial begin
        rst      = 1'b1;
        en       = 1'b0;
        center   = 1'b0;
        prescale = '0;
        period   = '0;
        duty_in  = '0;
        duty_we  = '0;
        model_reset();
        cycle();
        cycle();
        check_eq("reset_pwm", 32'(pwm), 32'd0);
        check_eq("reset_cycle_start", 32'(cycle_start), 32'd0);
        rst = 1'b0;

        for (int seg = 0; seg < 30; seg++) begin
            // Setup with the generator disabled: prescale only changes here.
            en       = 1'b0;
            prescale = PRESC_W'($urandom_range(0, 3));
            period   = (seg == 0) ? WIDTH'(15) : WIDTH'($urandom_range(0, 15));
            center   = (seg == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            for (int ch = 0; ch < CHANNELS; ch++) begin
                duty_in = (seg == 0 && ch == 0) ? WIDTH'(4) : rand_duty();
                duty_we = CHANNELS'(1 << ch);
                cycle();
            end
            duty_we = '0;
            cycle();

            en = 1'b1;
            for (int n = 0; n < 240; n++) begin
                rst     = ($urandom_range(0, 299) == 0);
                en      = ($urandom_range(0, 59) != 0);
                duty_we = '0;
                if ($urandom_range(0, 7) == 0) begin
                    duty_in = rand_duty();
                    duty_we = ($urandom_range(0, 3) == 0) ? {CHANNELS{1'b1}}
                                                          : CHANNELS'($urandom_range(1, 15));
                end
                if ($urandom_range(0, 19) == 0) period = WIDTH'($urandom_range(0, 15));
                if ($urandom_range(0, 29) == 0) center = ~center;
                cycle();
            end
            rst     = 1'b0;
            duty_we = '0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
